oclib_reset_sequencer: RTL

Central reset source that drives the per-module reset inputs of a subsystem, one output per downstream module reset input.
- Accepts an asynchronous active-high reset plus a synchronous soft-reset request.
- Stretches reset to a guaranteed minimum width.
- Releases its outputs one at a time in index order with a programmable gap, then raises done.
- Sits at subsystem top.

---
 rtl/oclib_pkg.sv | 20 ++
 rtl/oclib_reset_sync_chain.sv | 46 ++++
 rtl/oclib_reset_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/oclib_pkg.sv
// Shared types for the oclib reset blocks: boolean enum used as a parameter type
// and the reset sequencer state encoding.
package oclib_pkg;

    typedef enum logic {
        False = 1'b0,
        True  = 1'b1
    } oclib_bool_e;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } oclib_reset_seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/oclib_reset_sync_chain.sv
// Async-assert / sync-deassert reset chain: out rises with in immediately and
// falls on the SyncCycles-th rising clock edge that samples in low.
module oclib_reset_sync_chain
    import oclib_pkg::*;
#(
    parameter int          SyncCycles = 3,
    parameter oclib_bool_e DontTouch  = True
) (
    input  logic clock,
    input  logic in,
    output logic out
);

    if (SyncCycles < 2) begin : g_bad_sync_cycles
        $error("oclib_reset_sync_chain: SyncCycles must be >= 2");
    end

    if (DontTouch == True) begin : g_keep
        (* keep = "true", dont_touch = "true", async_reg = "true" *)
        logic [SyncCycles-1:0] r_chain;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clock or posedge in) begin
            if (in) begin
                r_chain <= '1;
            end else begin
                r_chain <= {r_chain[SyncCycles-2:0], 1'b0};
            end
        end

        assign out = r_chain[SyncCycles-1];
    end else begin : g_plain
        logic [SyncCycles-1:0] r_chain;

        always_ff @(posedge clock or posedge in) begin
            if (in) begin
                r_chain <= '1;
            end else begin
                r_chain <= {r_chain[SyncCycles-2:0], 1'b0};
            end
        end

        assign out = r_chain[SyncCycles-1];
    end

endmodule

// File: rtl/oclib_reset_sequencer.sv
// Central reset source: stretches reset to AssertCycles, then releases resetOut
// bits one at a time in index order, ReleaseGap cycles apart, and raises done.
module oclib_reset_sequencer
    import oclib_pkg::*;
#(
    parameter int          Outputs      = 3,
    parameter int          SyncCycles   = 3,
    parameter int          AssertCycles = 16,
    parameter int          ReleaseGap   = 4,
    parameter oclib_bool_e DontTouch    = True
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               resetRequest,
    output logic [Outputs-1:0] resetOut,
    output logic               done
);

    if (Outputs < 1 || AssertCycles < 1 || SyncCycles < 2) begin : g_bad_params
        $error("oclib_reset_sequencer: need Outputs>=1, AssertCycles>=1, SyncCycles>=2");
    end

    localparam int CntW = $clog2(max_int(AssertCycles, ReleaseGap) + 1);
    localparam int IdxW = $clog2(Outputs + 1);

    localparam logic [CntW-1:0] AssertLast = CntW'(AssertCycles - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'((ReleaseGap > 0) ? ReleaseGap - 1 : 0);
    localparam logic [IdxW-1:0] IdxLast    = IdxW'(Outputs - 1);
    // With no gap, or a single output, everything releases on the ASSERT exit edge.
    localparam bit AllAtOnce = (ReleaseGap == 0) || (Outputs == 1);

    logic                   w_rst;
    oclib_reset_seq_state_e r_state;
    oclib_reset_seq_state_e w_state_next;
    logic [CntW-1:0]        r_count;
    logic [CntW-1:0]        w_count_next;
    logic [IdxW-1:0]        r_idx;
    logic [IdxW-1:0]        w_idx_next;
    logic [Outputs-1:0]     w_out_next;
    logic                   w_done_next;

    oclib_reset_sync_chain #(
        .SyncCycles (SyncCycles),
        .DontTouch  (DontTouch)
    ) u_sync (
        .clock (clock),
        .in    (reset),
        .out   (w_rst)
    );

    always_ff @(posedge clock or posedge w_rst) begin
        if (w_rst) begin
            r_state <= ASSERT;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_idx   <= w_idx_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_idx_next   = r_idx;
        w_out_next   = resetOut;
        w_done_next  = done;

        if (resetRequest) begin
            w_state_next = ASSERT;
            w_count_next = '0;
            w_idx_next   = '0;
            w_out_next   = '1;
            w_done_next  = 1'b0;
        end else begin
            case (r_state)
                ASSERT: begin
                    if (r_count == AssertLast) begin
                        w_count_next = '0;
                        if (AllAtOnce) begin
                            w_out_next   = '0;
                            w_done_next  = 1'b1;
                            w_state_next = DONE;
                        end else begin
                            w_out_next[0] = 1'b0;
                            w_idx_next    = IdxW'(1);
                            w_state_next  = RELEASE;
                        end
                    end else begin
                        w_count_next = r_count + CntW'(1);
                    end
                end
                RELEASE: begin
                    if (r_count == GapLast) begin
                        w_count_next      = '0;
                        w_out_next[r_idx] = 1'b0;
                        if (r_idx == IdxLast) begin
                            w_done_next  = 1'b1;
                            w_state_next = DONE;
                        end else begin
                            w_idx_next = r_idx + IdxW'(1);
                        end
                    end else begin
                        w_count_next = r_count + CntW'(1);
                    end
                end
                DONE: begin
                    w_out_next  = '0;
                    w_done_next = 1'b1;
                end
                default: begin
                    w_state_next = ASSERT;
                    w_count_next = '0;
                    w_idx_next   = '0;
                    w_out_next   = '1;
                    w_done_next  = 1'b0;
                end
            endcase
        end
    end

    // Output flops sit in their own process so keep attributes can be applied selectively.
    if (DontTouch == True) begin : g_out_keep
        (* keep = "true", dont_touch = "true" *) logic [Outputs-1:0] r_out;
        (* keep = "true", dont_touch = "true" *) logic               r_done;

        always_ff @(posedge clock or posedge w_rst) begin
            if (w_rst) begin
                r_out  <= '1;
                r_done <= 1'b0;
            end else begin
                r_out  <= w_out_next;
                r_done <= w_done_next;
            end
        end

        assign resetOut = r_out;
        assign done     = r_done;
    end else begin : g_out_plain
        logic [Outputs-1:0] r_out;
        logic               r_done;

        always_ff @(posedge clock or posedge w_rst) begin
            if (w_rst) begin
                r_out  <= '1;
                r_done <= 1'b0;
            end else begin
                r_out  <= w_out_next;
                r_done <= w_done_next;
            end
        end

        assign resetOut = r_out;
        assign done     = r_done;
    end

endmodule
